// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // FSM states; encodings 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_WB  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Register file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // True for every opcode the control unit knows how to sequence
  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: is_supported_op = 1'b1;
      default:                               is_supported_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational output decoder: maps the current FSM state (and the opcode
// where a state needs it) onto every datapath control signal.
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN (adds mem_ready gating in FETCH).
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         OP,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               illegal_op
);

  // Moore decode: everything defaults to 0, each state raises only its own signals
  always_comb begin
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    BranchEQ   = 1'b0;
    BranchNE   = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALU_ADD;
    RegDst     = REGDST_RT;
    MemtoReg   = M2R_ALUOUT;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    case (state)
      STATE_W'(S_FETCH): begin
        MemRead = 1'b1;
`ifdef MULTICYCLE_MEM_WAIT_EN
        // IR and PC must only load on the cycle the memory returns data
        IRWrite = mem_ready;
        PCWrite = mem_ready;
`else
        IRWrite = 1'b1;
        PCWrite = 1'b1;
`endif
        ALUSrcB = SRCB_FOUR;
      end
      STATE_W'(S_DECODE): begin
        ALUSrcB    = SRCB_IMMSH2;
        illegal_op = ~is_supported_op(OP);
      end
      STATE_W'(S_MEM_ADDR): begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      STATE_W'(S_MEM_RD): begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      STATE_W'(S_LOAD_WB): begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
      end
      STATE_W'(S_MEM_WR): begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      STATE_W'(S_EXEC_R): begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTYPE;
      end
      STATE_W'(S_WB_R): begin
        RegDst   = REGDST_RD;
        RegWrite = 1'b1;
      end
      STATE_W'(S_EXEC_I): begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (OP)
          OP_ORI:  ALUOp = ALU_OR;
          OP_LUI:  ALUOp = ALU_LUI;
          default: ALUOp = ALU_ADD;
        endcase
      end
      STATE_W'(S_WB_I): begin
        RegWrite = 1'b1;
      end
      STATE_W'(S_BRANCH): begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSrc    = PCSRC_ALUOUT;
        BranchEQ = (OP == OP_BEQ);
        BranchNE = (OP == OP_BNE);
      end
      STATE_W'(S_JUMP): begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      STATE_W'(S_JAL): begin
        // PC already holds PC+4, so it is the link value written to $ra
        PCWrite  = 1'b1;
        PCSrc    = PCSRC_JUMP;
        RegDst   = REGDST_RA;
        MemtoReg = M2R_PC;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register plus next-state logic; all
// control outputs come from the multicycle_ctrl_outdec decoder.
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN (memory states wait on mem_ready).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic               w_mem_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_mem_go = mem_ready;
`else
  assign w_mem_go = 1'b1;
`endif

  // State register; reset drops straight back to FETCH, abandoning any instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= STATE_W'(S_FETCH);
    else        r_state <= w_next_state;
  end

  // Next-state sequencing; unknown states and illegal opcodes return to FETCH
  always_comb begin
    w_next_state = STATE_W'(S_FETCH);
    case (r_state)
      STATE_W'(S_FETCH):    w_next_state = w_mem_go ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      STATE_W'(S_DECODE): begin
        case (OP)
          OP_LW, OP_SW:          w_next_state = STATE_W'(S_MEM_ADDR);
          OP_RTYPE:              w_next_state = STATE_W'(S_EXEC_R);
          OP_ADDI, OP_ORI, OP_LUI: w_next_state = STATE_W'(S_EXEC_I);
          OP_BEQ, OP_BNE:        w_next_state = STATE_W'(S_BRANCH);
          OP_J:                  w_next_state = STATE_W'(S_JUMP);
          OP_JAL:                w_next_state = STATE_W'(S_JAL);
          default:               w_next_state = STATE_W'(S_FETCH);
        endcase
      end
      STATE_W'(S_MEM_ADDR): w_next_state = (OP == OP_LW) ? STATE_W'(S_MEM_RD) : STATE_W'(S_MEM_WR);
      STATE_W'(S_MEM_RD):   w_next_state = w_mem_go ? STATE_W'(S_LOAD_WB) : STATE_W'(S_MEM_RD);
      STATE_W'(S_MEM_WR):   w_next_state = w_mem_go ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WR);
      STATE_W'(S_EXEC_R):   w_next_state = STATE_W'(S_WB_R);
      STATE_W'(S_EXEC_I):   w_next_state = STATE_W'(S_WB_I);
      default:              w_next_state = STATE_W'(S_FETCH);
    endcase
  end

  assign state_o = r_state;

  multicycle_ctrl_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .state      (r_state),
    .OP         (OP),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: steps each instruction class through
// its state sequence and checks state and control outputs cycle by cycle.
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN (enables the mem_ready test).
module tb_multicycle_control;

  // State encodings of the design
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                         LOAD_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7,
                         EXEC_I = 4'd8, WB_I = 4'd9, BRANCH = 4'd10, JUMP = 4'd11, JALS = 4'd12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OP = 6'h00;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE;
  logic [1:0] PCSrc, ALUSrcB, RegDst, MemtoReg;
  logic       ALUSrcA, RegWrite, illegal_op;
  logic [2:0] ALUOp;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  task automatic test_reset();
    reset = 1'b0;
    OP    = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_o, FETCH); end
    n_checks++; if ({MemRead, IRWrite, PCWrite} !== 3'b111) begin n_fail++; $display("FAIL reset_fetch_strobes: got %b want 111", {MemRead, IRWrite, PCWrite}); end
    n_checks++; if (ALUSrcB !== 2'b01) begin n_fail++; $display("FAIL reset_alusrcb: got %b want 01", ALUSrcB); end
    n_checks++; if ({illegal_op, RegWrite, MemWrite, IorD, ALUSrcA} !== 5'b0) begin n_fail++; $display("FAIL reset_zeros: got %b want 00000", {illegal_op, RegWrite, MemWrite, IorD, ALUSrcA}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [4];
    exp_s = '{FETCH, DECODE, EXEC_R, WB_R};
    OP = 6'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (state_o !== exp_s[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); end
      if (i == 1) begin
        n_checks++; if ({ALUSrcA, ALUSrcB, ALUOp, PCWrite} !== {1'b0, 2'b11, 3'b000, 1'b0}) begin n_fail++; $display("FAIL decode_outputs: got %b want 0110000", {ALUSrcA, ALUSrcB, ALUOp, PCWrite}); end
      end
      if (i == 2) begin
        n_checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 2'b00, 3'b111}) begin n_fail++; $display("FAIL exec_r_outputs: got %b want 100111", {ALUSrcA, ALUSrcB, ALUOp}); end
      end
      n_checks++; if (RegWrite !== (i == 3)) begin n_fail++; $display("FAIL rtype_regwrite[%0d]: got %b want %b", i, RegWrite, (i == 3)); end
      if (i == 3) begin
        n_checks++; if ({RegDst, MemtoReg} !== 4'b0100) begin n_fail++; $display("FAIL wb_r_sel: got %b want 0100", {RegDst, MemtoReg}); end
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL rtype_end: got %0d want %0d", state_o, FETCH); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5];
    exp_s = '{FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB};
    OP = 6'h23;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (state_o !== exp_s[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); end
      n_checks++; if (MemRead && MemWrite) begin n_fail++; $display("FAIL lw_rd_wr_overlap[%0d]: got 11 want not both", i); end
      if (i == 2) begin
        n_checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 2'b10, 3'b000}) begin n_fail++; $display("FAIL mem_addr_outputs: got %b want 110000", {ALUSrcA, ALUSrcB, ALUOp}); end
      end
      if (i == 3) begin
        n_checks++; if ({IorD, MemRead, IRWrite, RegWrite} !== 4'b1100) begin n_fail++; $display("FAIL mem_rd_outputs: got %b want 1100", {IorD, MemRead, IRWrite, RegWrite}); end
      end
      if (i == 4) begin
        n_checks++; if ({RegDst, MemtoReg, RegWrite} !== 5'b00011) begin n_fail++; $display("FAIL load_wb_outputs: got %b want 00011", {RegDst, MemtoReg, RegWrite}); end
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL lw_end: got %0d want %0d", state_o, FETCH); end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4];
    exp_s = '{FETCH, DECODE, MEM_ADDR, MEM_WR};
    OP = 6'h2b;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (state_o !== exp_s[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); end
      n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite[%0d]: got %b want 0", i, RegWrite); end
      if (i == 3) begin
        n_checks++; if ({IorD, MemWrite, MemRead} !== 3'b110) begin n_fail++; $display("FAIL mem_wr_outputs: got %b want 110", {IorD, MemWrite, MemRead}); end
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL sw_end: got %0d want %0d", state_o, FETCH); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2];
    logic [1:0] exp_br [2];
    ops    = '{6'h05, 6'h04};
    exp_br = '{2'b01, 2'b10};  // {BranchEQ, BranchNE}
    for (int k = 0; k < 2; k++) begin
      OP = ops[k];
      #1;
      n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL br%0d_fetch: got %0d want %0d", k, state_o, FETCH); end
      @(negedge clk); #1;
      n_checks++; if ({state_o, BranchEQ, BranchNE} !== {DECODE, 2'b00}) begin n_fail++; $display("FAIL br%0d_decode: got %b want %b", k, {state_o, BranchEQ, BranchNE}, {DECODE, 2'b00}); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== BRANCH) begin n_fail++; $display("FAIL br%0d_state: got %0d want %0d", k, state_o, BRANCH); end
      n_checks++; if ({BranchEQ, BranchNE} !== exp_br[k]) begin n_fail++; $display("FAIL br%0d_flags: got %b want %b", k, {BranchEQ, BranchNE}, exp_br[k]); end
      n_checks++; if ({ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite} !== {1'b1, 2'b00, 3'b001, 2'b01, 1'b0}) begin n_fail++; $display("FAIL br%0d_outputs: got %b want 100001010", k, {ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite}); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL br%0d_end: got %0d want %0d", k, state_o, FETCH); end
    end
  endtask

  task automatic test_jumps();
    // J
    OP = 6'h02;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state_o !== JUMP) begin n_fail++; $display("FAIL j_state: got %0d want %0d", state_o, JUMP); end
    n_checks++; if ({PCWrite, PCSrc, RegWrite} !== 4'b1100) begin n_fail++; $display("FAIL j_outputs: got %b want 1100", {PCWrite, PCSrc, RegWrite}); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL j_end: got %0d want %0d", state_o, FETCH); end
    // JAL
    OP = 6'h03;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state_o !== JALS) begin n_fail++; $display("FAIL jal_state: got %0d want %0d", state_o, JALS); end
    n_checks++; if ({PCWrite, PCSrc, RegDst, MemtoReg, RegWrite} !== 8'b1_10_10_10_1) begin n_fail++; $display("FAIL jal_outputs: got %b want 11010101", {PCWrite, PCSrc, RegDst, MemtoReg, RegWrite}); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL jal_end: got %0d want %0d", state_o, FETCH); end
  endtask

  task automatic test_imm();
    logic [5:0] ops [3];
    logic [2:0] exp_op [3];
    ops    = '{6'h08, 6'h0d, 6'h0f};
    exp_op = '{3'b000, 3'b101, 3'b110};
    for (int k = 0; k < 3; k++) begin
      OP = ops[k];
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (state_o !== EXEC_I) begin n_fail++; $display("FAIL imm%0d_exec_state: got %0d want %0d", k, state_o, EXEC_I); end
      n_checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 2'b10, exp_op[k]}) begin n_fail++; $display("FAIL imm%0d_exec_outputs: got %b want %b", k, {ALUSrcA, ALUSrcB, ALUOp}, {1'b1, 2'b10, exp_op[k]}); end
      @(negedge clk); #1;
      n_checks++; if ({state_o, RegDst, MemtoReg, RegWrite} !== {WB_I, 5'b00001}) begin n_fail++; $display("FAIL imm%0d_wb: got %b want %b", k, {state_o, RegDst, MemtoReg, RegWrite}, {WB_I, 5'b00001}); end
      @(negedge clk); #1;
      n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL imm%0d_end: got %0d want %0d", k, state_o, FETCH); end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp_s [3];
    exp_s = '{FETCH, DECODE, FETCH};
    OP = 6'h3f;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (state_o !== exp_s[i]) begin n_fail++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]); end
      n_checks++; if (illegal_op !== (i == 1)) begin n_fail++; $display("FAIL illegal_pulse[%0d]: got %b want %b", i, illegal_op, (i == 1)); end
      n_checks++; if ({RegWrite, MemWrite} !== 2'b00) begin n_fail++; $display("FAIL illegal_writes[%0d]: got %b want 00", i, {RegWrite, MemWrite}); end
      if (i < 2) @(negedge clk);
    end
    OP = 6'h00;
  endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
  task automatic test_mem_wait();
    OP = 6'h00;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({state_o, MemRead, IRWrite, PCWrite} !== {FETCH, 3'b100}) begin n_fail++; $display("FAIL wait_fetch[%0d]: got %b want %b", i, {state_o, MemRead, IRWrite, PCWrite}, {FETCH, 3'b100}); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if ({state_o, IRWrite, PCWrite} !== {FETCH, 2'b11}) begin n_fail++; $display("FAIL wait_ready: got %b want %b", {state_o, IRWrite, PCWrite}, {FETCH, 2'b11}); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== DECODE) begin n_fail++; $display("FAIL wait_decode: got %0d want %0d", state_o, DECODE); end
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    OP = 6'h08;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state_o !== EXEC_I) begin n_fail++; $display("FAIL rmid_exec: got %0d want %0d", state_o, EXEC_I); end
    reset = 1'b0;
    #1;
    n_checks++; if ({state_o, RegWrite} !== {FETCH, 1'b0}) begin n_fail++; $display("FAIL rmid_abort: got %b want %b", {state_o, RegWrite}, {FETCH, 1'b0}); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== FETCH) begin n_fail++; $display("FAIL rmid_hold: got %0d want %0d", state_o, FETCH); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({state_o, RegWrite} !== {DECODE, 1'b0}) begin n_fail++; $display("FAIL rmid_restart: got %b want %b", {state_o, RegWrite}, {DECODE, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_branch();
    test_jumps();
    test_imm();
    test_illegal();
`ifdef MULTICYCLE_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
